// File: rtl/latsnq_exer_pkg.sv
// Shared types and the characterisation vector table for the active-low-set
// D latch exerciser.
package latsnq_exer_pkg;

   localparam int NUM_VEC  = 6;
   localparam int SYNC_CYC = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_PULSE,
      ST_HOLD,
      ST_SETTLE,
      ST_SETTLE_IN,
      ST_SAMPLE,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      PS_NONE,
      PS_E,
      PS_SETN
   } pulse_sel_e;

   typedef struct packed {
      logic       d;
      pulse_sel_e pulse_sel;
      logic       e_bg;
      logic       sample_in_pulse;
      logic       exp_q;
   } vec_t;

   // Fields: d, pulse target, background E, sample during pulse, expected Q.
   function automatic vec_t get_vec(input logic [2:0] idx);
      vec_t v;
      v = '{1'b0, PS_NONE, 1'b0, 1'b0, 1'b0};
      case (idx)
         3'd0:    v = '{1'b0, PS_SETN, 1'b0, 1'b0, 1'b1};
         3'd1:    v = '{1'b0, PS_E,    1'b0, 1'b0, 1'b0};
         3'd2:    v = '{1'b1, PS_NONE, 1'b0, 1'b0, 1'b0};
         3'd3:    v = '{1'b1, PS_E,    1'b0, 1'b0, 1'b1};
         3'd4:    v = '{1'b0, PS_E,    1'b0, 1'b1, 1'b0};
         3'd5:    v = '{1'b0, PS_SETN, 1'b1, 1'b0, 1'b1};
         default: v = '{1'b0, PS_NONE, 1'b0, 1'b0, 1'b0};
      endcase
      return v;
   endfunction

endpackage

// File: rtl/latsnq_exer_sync2.sv
// Two-flop synchroniser bringing the latch Q output into the CLK domain.
module latsnq_exer_sync2
   import latsnq_exer_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/latsnq_arc_exerciser.sv
// Stimulus/check engine: walks the vector table through the latch, samples the
// synchronised Q and accumulates a saturating mismatch count.
module latsnq_arc_exerciser
   import latsnq_exer_pkg::*;
#(
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 2,
   parameter int LOOPS     = 1,
   parameter int ERRW      = 8
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   input  logic            Q_IN,
   output logic            E,
   output logic            D,
   output logic            SETN,
   output logic            BUSY,
   output logic            DONE,
   output logic            PASS,
   output logic [ERRW-1:0] ERR_CNT,
   output logic [2:0]      VEC_IDX
);

   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);
   localparam logic [3:0] SYNC_LD  = 4'(SYNC_CYC - 1);
   localparam logic [7:0] LOOP_LAST = 8'(LOOPS - 1);
   localparam logic [2:0] VEC_LAST  = 3'(NUM_VEC - 1);

   state_e          state_d, state_q;
   logic [3:0]      phase_d, phase_q;
   logic [7:0]      loop_d, loop_q;
   logic [2:0]      vec_d, vec_q;
   logic [ERRW-1:0] err_d, err_q;
   logic            e_d, e_q, d_d, d_q, setn_d, setn_q;
   logic            busy_d, busy_q, done_d, done_q, pass_d, pass_q;
   logic            q_sync;
   vec_t            vc, vn;

   latsnq_exer_sync2 u_sync (
      .clk (CLK),
      .rst (RST),
      .d   (Q_IN),
      .q   (q_sync)
   );

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      loop_d  = loop_q;
      vec_d   = vec_q;
      err_d   = err_q;
      done_d  = done_q;
      pass_d  = pass_q;
      vc      = get_vec(vec_q);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               state_d = ST_APPLY;
               phase_d = SETUP_LD;
               loop_d  = '0;
               vec_d   = '0;
               err_d   = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         ST_APPLY: begin
            if (phase_q == 4'd0) begin
               state_d = ST_PULSE;
               phase_d = PULSE_LD;
            end else begin
               phase_d = phase_q - 4'd1;
            end
         end
         ST_PULSE: begin
            if (phase_q == 4'd0) begin
               state_d = vc.sample_in_pulse ? ST_SETTLE_IN : ST_HOLD;
               phase_d = vc.sample_in_pulse ? SYNC_LD : HOLD_LD;
            end else begin
               phase_d = phase_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (phase_q == 4'd0) begin
               state_d = ST_SETTLE;
               phase_d = SYNC_LD;
            end else begin
               phase_d = phase_q - 4'd1;
            end
         end
         ST_SETTLE, ST_SETTLE_IN: begin
            if (phase_q == 4'd0) begin
               state_d = ST_SAMPLE;
            end else begin
               phase_d = phase_q - 4'd1;
            end
         end
         ST_SAMPLE: begin
            if ((q_sync != vc.exp_q) && (err_q != {ERRW{1'b1}})) begin
               err_d = err_q + ERRW'(1);
            end
            phase_d = SETUP_LD;
            if (vec_q < VEC_LAST) begin
               vec_d   = vec_q + 3'd1;
               state_d = ST_APPLY;
            end else if (loop_q < LOOP_LAST) begin
               loop_d  = loop_q + 8'd1;
               vec_d   = '0;
               state_d = ST_APPLY;
            end else begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Pin drive is a function of the next state so E/D/SETN come straight from flops.
      vn     = get_vec(vec_d);
      e_d    = 1'b0;
      d_d    = d_q;
      setn_d = 1'b1;
      case (state_d)
         ST_APPLY: begin
            d_d = vn.d;
            // Background E rises one cycle into APPLY, so E always falls after
            // a sampled pulse and is already high before a set-dominance SETN pulse.
            e_d = vn.e_bg & (state_q == ST_APPLY);
         end
         ST_PULSE: begin
            d_d    = vn.d;
            e_d    = vn.e_bg | (vn.pulse_sel == PS_E);
            setn_d = (vn.pulse_sel != PS_SETN);
         end
         ST_HOLD, ST_SETTLE: d_d = vn.d;
         ST_SETTLE_IN: begin
            d_d = vn.d;
            e_d = 1'b1;
         end
         ST_SAMPLE: begin
            d_d = vn.d;
            e_d = vn.sample_in_pulse;
         end
         default: ;
      endcase

      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         loop_q  <= '0;
         vec_q   <= '0;
         err_q   <= '0;
         e_q     <= 1'b0;
         d_q     <= 1'b0;
         setn_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         loop_q  <= loop_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
         e_q     <= e_d;
         d_q     <= d_d;
         setn_q  <= setn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign E       = e_q;
   assign D       = d_q;
   assign SETN    = setn_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign PASS    = pass_q;
   assign ERR_CNT = err_q;
   assign VEC_IDX = vec_q;

endmodule

// File: tb/tb_latsnq_arc_exerciser.sv
// Bench for the latch exerciser: behavioural latch models (ideal, stuck, no set
// dominance) feed Q_IN; run results are checked against a queued expectation.
module tb_latsnq_arc_exerciser;

   localparam int M_IDEAL    = 0;
   localparam int M_STUCK1   = 1;
   localparam int M_STUCK0   = 2;
   localparam int M_NOSETDOM = 3;
   localparam int PULSE_W    = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;

   // Default instance (a), LOOPS=3 instance (b), LOOPS=3 ERRW=2 instance (c).
   logic e_a, d_a, setn_a, busy_a, done_a, pass_a;
   logic [7:0] err_a;
   logic [2:0] vidx_a;
   logic q_a = 1'b0;
   int mode_a = M_IDEAL;

   logic e_b, d_b, setn_b, busy_b, done_b, pass_b;
   logic [7:0] err_b;
   logic [2:0] vidx_b;
   logic q_b = 1'b0;
   int mode_b = M_IDEAL;

   logic e_c, d_c, setn_c, busy_c, done_c, pass_c;
   logic [1:0] err_c;
   logic [2:0] vidx_c;
   logic q_c = 1'b0;
   int mode_c = M_IDEAL;

   logic [15:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   logic mon_clr = 1'b0;
   logic e_prev = 1'b0;
   logic setn_prev = 1'b1;
   int e_rise = 0;
   int setn_fall = 0;
   int setn_bad = 0;
   int setn_w = 0;

   always #5 clk = ~clk;

   latsnq_arc_exerciser dut (
      .CLK(clk), .RST(rst), .START(start), .Q_IN(q_a),
      .E(e_a), .D(d_a), .SETN(setn_a), .BUSY(busy_a), .DONE(done_a),
      .PASS(pass_a), .ERR_CNT(err_a), .VEC_IDX(vidx_a)
   );

   latsnq_arc_exerciser #(.LOOPS(3)) dut_b (
      .CLK(clk), .RST(rst), .START(start), .Q_IN(q_b),
      .E(e_b), .D(d_b), .SETN(setn_b), .BUSY(busy_b), .DONE(done_b),
      .PASS(pass_b), .ERR_CNT(err_b), .VEC_IDX(vidx_b)
   );

   latsnq_arc_exerciser #(.LOOPS(3), .ERRW(2)) dut_c (
      .CLK(clk), .RST(rst), .START(start), .Q_IN(q_c),
      .E(e_c), .D(d_c), .SETN(setn_c), .BUSY(busy_c), .DONE(done_c),
      .PASS(pass_c), .ERR_CNT(err_c), .VEC_IDX(vidx_c)
   );

   function automatic logic latch_eval(input int mode, input logic e, input logic d,
                                       input logic setn, input logic qprev);
      logic q;
      q = qprev;
      case (mode)
         M_IDEAL: begin
            if (!setn) q = 1'b1;
            else if (e) q = d;
         end
         M_STUCK1: q = 1'b1;
         M_STUCK0: q = 1'b0;
         M_NOSETDOM: begin
            if (e) q = d;
            else if (!setn) q = 1'b1;
         end
         default: q = qprev;
      endcase
      return q;
   endfunction

   always @(mode_a or e_a or d_a or setn_a) q_a = latch_eval(mode_a, e_a, d_a, setn_a, q_a);
   always @(mode_b or e_b or d_b or setn_b) q_b = latch_eval(mode_b, e_b, d_b, setn_b, q_b);
   always @(mode_c or e_c or d_c or setn_c) q_c = latch_eval(mode_c, e_c, d_c, setn_c, q_c);

   // Pin activity on instance a: E rising edges, SETN low pulses and their widths.
   always @(posedge clk) begin
      if (mon_clr) begin
         e_rise    <= 0;
         setn_fall <= 0;
         setn_bad  <= 0;
         setn_w    <= 0;
      end else begin
         if (e_a && !e_prev) e_rise <= e_rise + 1;
         if (!setn_a && setn_prev) setn_fall <= setn_fall + 1;
         if (!setn_a) setn_w <= setn_w + 1;
         if (setn_a && !setn_prev) begin
            if (setn_w != PULSE_W) setn_bad <= setn_bad + 1;
            setn_w <= 0;
         end
      end
      e_prev    <= e_a;
      setn_prev <= setn_a;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One START pulse on instance a, then wait for DONE and score the run.
   task automatic run_a(input string tag, input int exp_cyc, input int exp_err,
                        input logic exp_pass, input bit poke_busy);
      int cyc;
      exp_q.push_back(16'(exp_cyc));
      exp_q.push_back(16'(exp_err));
      exp_q.push_back(16'(exp_pass));
      mon_clr = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mon_clr = 1'b0;
      check({tag, "_start_done"}, 16'(done_a), 16'd0);
      check({tag, "_start_err"}, 16'(err_a), 16'd0);
      check({tag, "_start_busy"}, 16'(busy_a), 16'd1);
      cyc = 0;
      while (done_a !== 1'b1 && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
         start = poke_busy && (cyc < 50) && (cyc % 13 == 5);
      end
      start = 1'b0;
      check({tag, "_cycles"}, 16'(cyc), exp_q.pop_front());
      check({tag, "_err_cnt"}, 16'(err_a), exp_q.pop_front());
      check({tag, "_pass"}, 16'(pass_a), exp_q.pop_front());
      check({tag, "_busy_end"}, 16'(busy_a), 16'd0);
   endtask

   initial begin
      int cyc;
      int per_run;
      per_run = 5 * (2 + 2 + 2 + 3 + 1) + (2 + 2 + 3 + 1);

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pins", 16'({e_a, d_a, setn_a}), 16'b001);
      check("rst_status", 16'({busy_a, done_a, pass_a}), 16'b000);
      check("rst_err", 16'(err_a), 16'd0);
      check("rst_vidx", 16'(vidx_a), 16'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Ideal latch: clean pass plus pin activity
      mode_a = M_IDEAL;
      run_a("ideal", per_run, 0, 1'b1, 1'b0);
      check("ideal_e_rises", 16'(e_rise), 16'd4);
      check("ideal_setn_pulses", 16'(setn_fall), 16'd2);
      check("ideal_setn_width", 16'(setn_bad), 16'd0);

      // Q stuck at 1: vectors 1, 2 and 4 miss
      mode_a = M_STUCK1;
      run_a("stuck1", per_run, 3, 1'b0, 1'b0);

      // START in DONE restarts with counters cleared; START while busy is ignored
      mode_a = M_IDEAL;
      run_a("restart_busy", per_run, 0, 1'b1, 1'b1);

      // No set dominance: only vector 5 misses
      mode_a = M_NOSETDOM;
      run_a("nosetdom", per_run, 1, 1'b0, 1'b0);

      // Reset during the E pulse of vector 3
      mode_a = M_IDEAL;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (!(vidx_a == 3'd3 && e_a === 1'b1) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("midrst_reached_v3", 16'(cyc < 200), 16'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_pins", 16'({e_a, setn_a}), 16'b01);
      check("midrst_busy", 16'(busy_a), 16'd0);
      check("midrst_err", 16'(err_a), 16'd0);
      check("midrst_done", 16'(done_a), 16'd0);
      check("midrst_vidx", 16'(vidx_a), 16'd0);
      run_a("after_rst", per_run, 0, 1'b1, 1'b0);

      // LOOPS=3 with Q stuck at 0: 3 misses per pass, and a 2-bit counter saturates
      rst = 1'b1;
      mode_b = M_STUCK0;
      mode_c = M_STUCK0;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.push_back(16'(3 * per_run));
      exp_q.push_back(16'd9);
      exp_q.push_back(16'd3);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (done_b !== 1'b1 && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("loops3_cycles", 16'(cyc), exp_q.pop_front());
      check("loops3_err_cnt", 16'(err_b), exp_q.pop_front());
      check("loops3_pass", 16'(pass_b), 16'd0);
      check("sat_err_cnt", 16'(err_c), exp_q.pop_front());
      check("sat_done", 16'(done_c), 16'd1);
      check("sat_pass", 16'(pass_c), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
